uart_block_bridge: RTL and testbench

Parametrised byte-stream to block bridge between the UART byte-level receiver/transmitter and the AES core. The RX path packs BLOCK_BYTES received bytes into one block and presents it on a valid/ready interface. The TX path accepts a block on valid/ready and serialises it into bytes for the UART transmitter. Beyond the fixed 128-bit bridging it adds configurable block size, byte order, backpressure on both sides, a partial-block timeout, and sticky error flags.

---
 rtl/uart_bridge_pkg.sv | 14 +
 rtl/block_serializer.sv | 69 ++++++
 rtl/uart_block_bridge.sv | 115 +++++++++++
 tb/tb_uart_block_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types for the UART byte-stream <-> block bridge: byte width, FSM state enums,
// and the mapping from a byte's position on the wire to its bit lane in a block.
package uart_bridge_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {COLLECT, HOLD} rx_state_t;
    typedef enum logic {IDLE, SEND} tx_state_t;

    function automatic int lane_lo(input int idx, input bit msb_first, input int block_bytes);
        return msb_first ? (block_bytes - 1 - idx) * BYTE_W : idx * BYTE_W;
    endfunction

endpackage

// File: rtl/block_serializer.sv
// Latches one block on valid/ready and emits it as bytes; first byte is valid one cycle after accept.
// Each byte is held until tx_byte_ready; blk_in_ready stays low until the last byte is taken.
module block_serializer
    import uart_bridge_pkg::*;
#(
    parameter int BLOCK_BYTES = 16,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BYTE_W*BLOCK_BYTES-1:0] blk_in,
    input  logic                          blk_in_valid,
    output logic                          blk_in_ready,
    output logic [BYTE_W-1:0]             tx_byte,
    output logic                          tx_byte_valid,
    input  logic                          tx_byte_ready
);

    localparam int CNT_W = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BYTES - 1);
    localparam int FIRST_SH = lane_lo(0, MSB_FIRST, BLOCK_BYTES);

    tx_state_t                     state;
    logic [BYTE_W*BLOCK_BYTES-1:0] blk_q;
    logic [CNT_W-1:0]              tx_cnt;
    int                            nxt_sh;

    always_comb begin
        nxt_sh = lane_lo(int'(tx_cnt) + 1, MSB_FIRST, BLOCK_BYTES);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            blk_in_ready  <= 1'b0;
            tx_byte_valid <= 1'b0;
            tx_byte       <= '0;
            tx_cnt        <= '0;
            blk_q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    blk_in_ready <= 1'b1;
                    if (blk_in_valid && blk_in_ready) begin
                        blk_q         <= blk_in;
                        tx_cnt        <= '0;
                        tx_byte       <= BYTE_W'(blk_in >> FIRST_SH);
                        tx_byte_valid <= 1'b1;
                        blk_in_ready  <= 1'b0;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (tx_byte_ready) begin
                        if (tx_cnt == LAST) begin
                            tx_byte_valid <= 1'b0;
                            blk_in_ready  <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            tx_cnt  <= tx_cnt + 1'b1;
                            tx_byte <= BYTE_W'(blk_q >> nxt_sh);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_block_bridge.sv
// Packs UART bytes into blocks (valid 1 cycle after the last byte) and serialises blocks back to bytes.
// A byte arriving while a block is held and not accepted is dropped and flagged; stale partial blocks time out.
module uart_block_bridge
    import uart_bridge_pkg::*;
#(
    parameter int BLOCK_BYTES    = 16,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [BYTE_W-1:0]             rx_byte,
    input  logic                          rx_byte_valid,
    output logic [BYTE_W*BLOCK_BYTES-1:0] blk_out,
    output logic                          blk_out_valid,
    input  logic                          blk_out_ready,
    input  logic [BYTE_W*BLOCK_BYTES-1:0] blk_in,
    input  logic                          blk_in_valid,
    output logic                          blk_in_ready,
    output logic [BYTE_W-1:0]             tx_byte,
    output logic                          tx_byte_valid,
    input  logic                          tx_byte_ready,
    input  logic                          clear_flags,
    output logic                          rx_overflow,
    output logic                          rx_timeout
);

    localparam int BLK_W  = BYTE_W * BLOCK_BYTES;
    localparam int CNT_W  = $clog2(BLOCK_BYTES);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST      = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    rx_state_t         rx_state;
    logic [CNT_W-1:0]  rx_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    int                wr_sh;
    logic [BLK_W-1:0]  wr_mask;
    logic [BLK_W-1:0]  wr_data;

    // A byte accepted in HOLD always starts the next block, so it lands in lane 0.
    always_comb begin
        wr_sh   = lane_lo((rx_state == HOLD) ? 0 : int'(rx_cnt), MSB_FIRST, BLOCK_BYTES);
        wr_mask = BLK_W'({BYTE_W{1'b1}}) << wr_sh;
        wr_data = BLK_W'(rx_byte) << wr_sh;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state      <= COLLECT;
            rx_cnt        <= '0;
            idle_cnt      <= '0;
            blk_out       <= '0;
            blk_out_valid <= 1'b0;
            rx_overflow   <= 1'b0;
            rx_timeout    <= 1'b0;
        end else begin
            // Later set assignments override this clear within the same cycle.
            if (clear_flags) begin
                rx_overflow <= 1'b0;
                rx_timeout  <= 1'b0;
            end
            case (rx_state)
                COLLECT: begin
                    if (rx_byte_valid) begin
                        blk_out  <= (blk_out & ~wr_mask) | wr_data;
                        idle_cnt <= '0;
                        if (rx_cnt == LAST) begin
                            rx_cnt        <= '0;
                            blk_out_valid <= 1'b1;
                            rx_state      <= HOLD;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end else if (TIMEOUT_CYCLES > 0 && rx_cnt != '0) begin
                        if (idle_cnt == IDLE_LAST) begin
                            rx_cnt     <= '0;
                            idle_cnt   <= '0;
                            rx_timeout <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (blk_out_ready) begin
                        blk_out_valid <= 1'b0;
                        rx_state      <= COLLECT;
                        if (rx_byte_valid) begin
                            blk_out <= (blk_out & ~wr_mask) | wr_data;
                            rx_cnt  <= CNT_W'(1);
                        end
                    end else if (rx_byte_valid) begin
                        rx_overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

    block_serializer #(
        .BLOCK_BYTES(BLOCK_BYTES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_serializer (
        .clk          (clk),
        .reset        (reset),
        .blk_in       (blk_in),
        .blk_in_valid (blk_in_valid),
        .blk_in_ready (blk_in_ready),
        .tx_byte      (tx_byte),
        .tx_byte_valid(tx_byte_valid),
        .tx_byte_ready(tx_byte_ready)
    );

endmodule

// File: tb/tb_uart_block_bridge.sv
// Two bridges share stimulus: a = MSB-first with a 10-cycle timeout, b = LSB-first without timeout.
module tb_uart_block_bridge;

    localparam int NB = 16;
    localparam int BW = 8 * NB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]    rx_byte = '0;
    logic          rx_byte_valid = 1'b0, blk_out_ready = 1'b0, blk_in_valid = 1'b0;
    logic          tx_byte_ready = 1'b0, clear_flags = 1'b0;
    logic [BW-1:0] blk_in = '0;

    logic [BW-1:0] blk_out [2];
    logic [7:0]    tx_byte [2];
    logic          blk_out_valid [2], blk_in_ready [2], tx_byte_valid [2];
    logic          rx_overflow [2], rx_timeout [2];

    uart_block_bridge #(.BLOCK_BYTES(NB), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(10)) dut_a (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .blk_out(blk_out[0]), .blk_out_valid(blk_out_valid[0]), .blk_out_ready(blk_out_ready),
        .blk_in(blk_in), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready[0]),
        .tx_byte(tx_byte[0]), .tx_byte_valid(tx_byte_valid[0]), .tx_byte_ready(tx_byte_ready),
        .clear_flags(clear_flags), .rx_overflow(rx_overflow[0]), .rx_timeout(rx_timeout[0]));

    uart_block_bridge #(.BLOCK_BYTES(NB), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
        .blk_out(blk_out[1]), .blk_out_valid(blk_out_valid[1]), .blk_out_ready(blk_out_ready),
        .blk_in(blk_in), .blk_in_valid(blk_in_valid), .blk_in_ready(blk_in_ready[1]),
        .tx_byte(tx_byte[1]), .tx_byte_valid(tx_byte_valid[1]), .tx_byte_ready(tx_byte_ready),
        .clear_flags(clear_flags), .rx_overflow(rx_overflow[1]), .rx_timeout(rx_timeout[1]));

    int tests = 0;
    int fails = 0;

    // Reference model: bytes gathered so far, the held block, flags, and the block being sent.
    logic [7:0]    pb [2][NB];
    int            pn [2];
    bit            hold [2];
    logic [BW-1:0] held [2];
    int            idle [2];
    bit            ovf [2], tmo [2];
    bit            tx_busy, tx_up;
    logic [BW-1:0] tx_blk;
    int            tx_k;

    logic [7:0] prev_tx [2];
    bit         prev_vld [2];
    bit         rec = 1'b0;
    logic [7:0] seen_a [$];
    logic [7:0] seen_b [$];

    function automatic int tmo_of(input int i);
        return (i == 0) ? 10 : 0;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 0);
    endfunction

    function automatic int pos_of(input int k, input bit msb);
        return msb ? (NB - 1 - k) : k;
    endfunction

    function automatic logic [7:0] nth_byte(input logic [BW-1:0] b, input int k, input bit msb);
        return 8'(b >> (8 * pos_of(k, msb)));
    endfunction

    function automatic logic [BW-1:0] pack(input int i);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++)
            r = r | (BW'(pb[i][k]) << (8 * pos_of(k, msb_of(i))));
        return r;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pn[i] = 0; hold[i] = 0; held[i] = '0; idle[i] = 0; ovf[i] = 0; tmo[i] = 0;
        end
        tx_busy = 0; tx_up = 0; tx_k = 0; tx_blk = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit so, st;
            so = 0; st = 0;
            if (hold[i]) begin
                if (blk_out_ready) begin
                    hold[i] = 0; pn[i] = 0;
                    if (rx_byte_valid) begin pb[i][0] = rx_byte; pn[i] = 1; end
                end else if (rx_byte_valid) so = 1;
            end else if (rx_byte_valid) begin
                pb[i][pn[i]] = rx_byte; pn[i]++; idle[i] = 0;
                if (pn[i] == NB) begin held[i] = pack(i); hold[i] = 1; pn[i] = 0; end
            end else if (pn[i] > 0 && tmo_of(i) > 0) begin
                idle[i]++;
                if (idle[i] == tmo_of(i)) begin pn[i] = 0; idle[i] = 0; st = 1; end
            end
            if (clear_flags) begin ovf[i] = 0; tmo[i] = 0; end
            if (so) ovf[i] = 1;
            if (st) tmo[i] = 1;
        end
        if (!tx_busy) begin
            if (tx_up && blk_in_valid) begin tx_busy = 1; tx_blk = blk_in; tx_k = 0; end
        end else if (tx_byte_ready) begin
            tx_k++;
            if (tx_k == NB) tx_busy = 0;
        end
        tx_up = 1;
    endtask

    task automatic compare();
        for (int i = 0; i < 2; i++) begin
            string s;
            s = (i == 0) ? "a" : "b";
            check({s, ".blk_out_valid"}, BW'(blk_out_valid[i]), BW'(hold[i]));
            if (hold[i]) check({s, ".blk_out"}, blk_out[i], held[i]);
            check({s, ".rx_overflow"}, BW'(rx_overflow[i]), BW'(ovf[i]));
            check({s, ".rx_timeout"}, BW'(rx_timeout[i]), BW'(tmo[i]));
            check({s, ".tx_byte_valid"}, BW'(tx_byte_valid[i]), BW'(tx_busy));
            if (tx_busy) check({s, ".tx_byte"}, BW'(tx_byte[i]), BW'(nth_byte(tx_blk, tx_k, msb_of(i))));
            check({s, ".blk_in_ready"}, BW'(blk_in_ready[i]), BW'(tx_up && !tx_busy));
        end
    endtask

    always @(posedge clk) begin
        if (rec && tx_byte_ready) begin
            if (prev_vld[0]) seen_a.push_back(prev_tx[0]);
            if (prev_vld[1]) seen_b.push_back(prev_tx[1]);
        end
        if (!reset) model_reset();
        else model_step();
        #1;
        compare();
        for (int i = 0; i < 2; i++) begin
            prev_vld[i] = tx_byte_valid[i];
            prev_tx[i]  = tx_byte[i];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic ordy);
        rx_byte = b; rx_byte_valid = 1'b1; blk_out_ready = ordy;
        @(negedge clk);
        rx_byte_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check({tag, ".blk_out"}, blk_out[i], '0);
            check({tag, ".ctl"}, BW'({tx_byte[i], blk_out_valid[i], blk_in_ready[i],
                                      tx_byte_valid[i], rx_overflow[i], rx_timeout[i]}), '0);
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #2 all_zero("reset_state");
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("ready_after_release", BW'(blk_in_ready[0]), BW'(1));

        // Full block with the sink always ready.
        for (int b = 0; b < 16; b++) send(8'(b), 1'b1);
        check("blk1_valid", BW'(blk_out_valid[0]), BW'(1));
        check("blk1_a", blk_out[0], 128'h000102030405060708090A0B0C0D0E0F);
        check("blk1_b", blk_out[1], 128'h0F0E0D0C0B0A09080706050403020100);
        tick();
        check("blk1_one_cycle", BW'(blk_out_valid[0]), BW'(0));

        // Overflow while held, then clear.
        for (int b = 32; b < 48; b++) send(8'(b), 1'b0);
        send(8'hAA, 1'b0);
        check("ovf_set", BW'(rx_overflow[0]), BW'(1));
        check("ovf_blk_kept", blk_out[0], 128'h202122232425262728292A2B2C2D2E2F);
        pulse_clear();
        check("ovf_cleared", BW'(rx_overflow[0]), BW'(0));

        // Byte accepted in the same cycle as the held block.
        send(8'h55, 1'b1);
        check("hold_byte_no_ovf", BW'(rx_overflow[0]), BW'(0));
        for (int b = 1; b < 16; b++) send(8'(b), 1'b1);
        check("blk55_a", blk_out[0], 128'h55010203040506070809_0A0B0C0D0E0F);
        tick();

        // Timeout boundary, byte winning in the expiry cycle, then a clean block.
        for (int b = 0; b < 3; b++) send(8'h61 + 8'(b), 1'b1);
        repeat (9) tick();
        check("tmo_9", BW'(rx_timeout[0]), BW'(0));
        tick();
        check("tmo_10", BW'(rx_timeout[0]), BW'(1));
        check("tmo_disabled_b", BW'(rx_timeout[1]), BW'(0));
        pulse_clear();
        for (int b = 0; b < 3; b++) send(8'h61 + 8'(b), 1'b1);
        repeat (9) tick();
        send(8'h64, 1'b1);
        check("tmo_byte_wins", BW'(rx_timeout[0]), BW'(0));
        repeat (10) tick();
        check("tmo_again", BW'(rx_timeout[0]), BW'(1));
        pulse_clear();
        for (int b = 48; b < 64; b++) send(8'(b), 1'b1);
        check("blk_after_tmo", blk_out[0], 128'h303132333435363738393A3B3C3D3E3F);
        tick();

        // Serialise a block with a toggling transmitter.
        blk_in = 128'h0F0E0D0C0B0A09080706050403020100;
        blk_in_valid = 1'b1; rec = 1'b1;
        tick();
        blk_in_valid = 1'b0;
        for (int j = 0; j < 34; j++) begin
            tx_byte_ready = (j % 2 == 0);
            tick();
        end
        rec = 1'b0; tx_byte_ready = 1'b0;
        check("tx_count_a", BW'(seen_a.size()), BW'(16));
        check("tx_count_b", BW'(seen_b.size()), BW'(16));
        if (seen_a.size() == 16 && seen_b.size() == 16)
            for (int k = 0; k < 16; k++) begin
                check("tx_seq_b", BW'(seen_b[k]), BW'(k));
                check("tx_seq_a", BW'(seen_a[k]), BW'(15 - k));
            end
        check("tx_idle_ready", BW'(blk_in_ready[1]), BW'(1));

        // Randomised traffic on both paths, alternating busy and sparse byte rates.
        for (int seg = 0; seg < 8; seg++) begin
            int rate;
            rate = (seg % 2 == 1) ? 10 : 60;
            for (int n = 0; n < 250; n++) begin
                rx_byte_valid = ($urandom_range(99) < rate);
                rx_byte       = 8'($urandom);
                blk_out_ready = ($urandom_range(99) < 70);
                clear_flags   = ($urandom_range(99) < 3);
                blk_in_valid  = ($urandom_range(99) < 30);
                blk_in        = {$urandom, $urandom, $urandom, $urandom};
                tx_byte_ready = ($urandom_range(99) < 60);
                tick();
            end
        end
        rx_byte_valid = 1'b0; clear_flags = 1'b0; blk_in_valid = 1'b0;
        tx_byte_ready = 1'b1; blk_out_ready = 1'b1;
        repeat (20) tick();

        // Reset in the middle of RX and TX.
        blk_in = {$urandom, $urandom, $urandom, $urandom};
        tx_byte_ready = 1'b0; blk_out_ready = 1'b0;
        for (int j = 0; j < 7; j++) begin
            rx_byte = 8'(j); rx_byte_valid = 1'b1;
            blk_in_valid  = (j == 0);
            tx_byte_ready = (j >= 1 && j <= 5);
            tick();
        end
        rx_byte_valid = 1'b0; blk_in_valid = 1'b0; tx_byte_ready = 1'b0;
        reset = 1'b0;
        #1 all_zero("mid_reset");
        repeat (2) tick();
        reset = 1'b1;
        tick();
        for (int b = 16; b < 32; b++) send(8'(b), 1'b0);
        check("post_reset_blk_a", blk_out[0], 128'h101112131415161718191A1B1C1D1E1F);
        check("post_reset_blk_b", blk_out[1], 128'h1F1E1D1C1B1A19181716151413121110);
        check("post_reset_tx_idle", BW'({tx_byte_valid[0], blk_in_ready[0]}), BW'(2'b01));
        blk_out_ready = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
